// File: rtl/serial_match_sched.sv
// serial_match_sched: one bit-serial "011" Mealy detector shared by four
// channels. A round-robin scheduler grants one 8-bit word at a time, restores
// that channel's 2-bit detector context, shifts the word MSB-first through the
// detector, reports count/bitmap with a done pulse and writes the context back.
module serial_match_sched #(
   parameter int WORD_W = 8,
   parameter int N_CH   = 4,
   parameter int CNT_W  = $clog2(WORD_W + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_CH-1:0]        req,
   input  logic [N_CH*WORD_W-1:0] word_in,
   input  logic [N_CH-1:0]        clr_ctx,
   output logic [N_CH-1:0]        gnt,
   output logic                   busy,
   output logic                   done,
   output logic [1:0]             done_ch,
   output logic [CNT_W-1:0]       match_cnt,
   output logic [WORD_W-1:0]      match_map
);

   localparam int STEP_W = $clog2(WORD_W);
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(WORD_W - 1);

   // Detector context encodings; 2'b11 is never written and decodes as N.
   localparam logic [1:0] CTX_N  = 2'b00;
   localparam logic [1:0] CTX_Z  = 2'b01;
   localparam logic [1:0] CTX_ZO = 2'b10;

   typedef enum logic [1:0] {IDLE, SHIFT, WB} state_t;

   state_t              state, state_nxt;
   logic [1:0]          rr_ptr;
   logic [1:0]          act_ch;
   logic [1:0]          wctx;
   logic [WORD_W-1:0]   shreg;
   logic [STEP_W-1:0]   step;
   logic [CNT_W-1:0]    cnt;
   logic [WORD_W-1:0]   map;
   logic                clr_seen;
   logic [1:0]          ctx [N_CH];

   logic [WORD_W-1:0]   words [N_CH];
   logic [1:0]          sel;
   logic                sel_vld;
   logic                det_match;
   logic [1:0]          det_nxt;
   logic [CNT_W-1:0]    cnt_nxt;
   logic [WORD_W-1:0]   map_nxt;
   logic [STEP_W-1:0]   bit_idx;

   assign busy = (state != IDLE);

   // Unpack the flat word bus into one word per channel.
   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         words[i] = word_in[i*WORD_W +: WORD_W];
      end
   end

   // Round-robin pick: first requester at or after rr_ptr, wrapping 3 -> 0.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      sel     = '0;
      sel_vld = 1'b0;
      for (int k = N_CH - 1; k >= 0; k--) begin
         if (req[rr_ptr + 2'(k)]) begin
            sel     = rr_ptr + 2'(k);
            sel_vld = 1'b1;
         end
      end
   end

   // One detector step on the current MSB plus the resulting count/bitmap.
   always_comb begin
      det_match = 1'b0;
      det_nxt   = CTX_N;
      case (wctx)
         CTX_Z:   det_nxt = shreg[WORD_W-1] ? CTX_ZO : CTX_Z;
         CTX_ZO: begin
            det_nxt   = shreg[WORD_W-1] ? CTX_N : CTX_Z;
            det_match = shreg[WORD_W-1];
         end
         default: det_nxt = shreg[WORD_W-1] ? CTX_N : CTX_Z;
      endcase
      bit_idx          = LAST_STEP - step;
      cnt_nxt          = cnt + CNT_W'(det_match);
      map_nxt          = map;
      map_nxt[bit_idx] = map[bit_idx] | det_match;
   end

   // Controller next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (sel_vld) state_nxt = SHIFT;
         SHIFT:   if (step == LAST_STEP) state_nxt = WB;
         WB:      state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Controller state register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Datapath: grant/load, serial shift, result capture, context write-back.
   always_ff @(posedge clk) begin
      if (rst) begin
         gnt       <= '0;
         done      <= 1'b0;
         done_ch   <= '0;
         match_cnt <= '0;
         match_map <= '0;
         rr_ptr    <= '0;
         act_ch    <= '0;
         wctx      <= CTX_N;
         shreg     <= '0;
         step      <= '0;
         cnt       <= '0;
         map       <= '0;
         clr_seen  <= 1'b0;
         // NOTE: the context store is reset explicitly because every channel must restart from N.
         for (int i = 0; i < N_CH; i++) ctx[i] <= CTX_N;
      end else begin
         gnt  <= '0;
         done <= 1'b0;
         for (int i = 0; i < N_CH; i++) begin
            if (clr_ctx[i]) ctx[i] <= CTX_N;
         end
         case (state)
            IDLE: begin
               if (sel_vld) begin
                  gnt      <= N_CH'(1) << sel;
                  shreg    <= words[sel];
                  wctx     <= clr_ctx[sel] ? CTX_N : ctx[sel];
                  cnt      <= '0;
                  map      <= '0;
                  step     <= '0;
                  act_ch   <= sel;
                  clr_seen <= 1'b0;
               end
            end
            SHIFT: begin
               shreg <= shreg << 1;
               wctx  <= det_nxt;
               cnt   <= cnt_nxt;
               map   <= map_nxt;
               step  <= step + 1'b1;
               if (clr_ctx[act_ch]) clr_seen <= 1'b1;
               if (step == LAST_STEP) begin
                  done      <= 1'b1;
                  done_ch   <= act_ch;
                  match_cnt <= cnt_nxt;
                  match_map <= map_nxt;
               end
            end
            WB: begin
               ctx[act_ch] <= (clr_seen || clr_ctx[act_ch]) ? CTX_N : wctx;
               rr_ptr      <= act_ch + 2'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_match_sched.sv
// tb_serial_match_sched: table-driven word jobs with hand-computed results,
// plus sequences for round-robin order, mid-job reset and context clears.
module tb_serial_match_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] word_in;
   logic [3:0]  clr_ctx;
   logic [3:0]  gnt;
   logic        busy;
   logic        done;
   logic [1:0]  done_ch;
   logic [3:0]  match_cnt;
   logic [7:0]  match_map;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   serial_match_sched dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .word_in   (word_in),
      .clr_ctx   (clr_ctx),
      .gnt       (gnt),
      .busy      (busy),
      .done      (done),
      .done_ch   (done_ch),
      .match_cnt (match_cnt),
      .match_map (match_map)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         ch;
      logic [7:0] w;
      int         clr_ch;
      int         clr_step;  // 0 none, -1 with req, k>0 at k-th edge after gnt
      logic [3:0] cnt;
      logic [7:0] map;
   } vec_t;

   vec_t tbl [16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Submit one word, check grant, done latency and the reported result.
   task automatic run_job(input int ch, input logic [7:0] w, input int clr_ch,
                          input int clr_step, input logic [3:0] ecnt,
                          input logic [7:0] emap, input string tag);
      bit got;
      int lat;
      word_in[ch*8 +: 8] = w;
      req[ch] = 1'b1;
      if (clr_step < 0) clr_ctx[ch] = 1'b1;
      got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         tick();
         if (gnt != 4'b0) got = 1;
      end
      check({tag, " gnt"}, 32'(gnt), 32'd1 << ch);
      req     = '0;
      clr_ctx = '0;
      if (!got) return;
      check({tag, " busy"}, 32'(busy), 32'd1);
      got = 0;
      lat = 0;
      for (int i = 1; i <= 20 && !got; i++) begin
         if (clr_step > 0 && i == clr_step) clr_ctx = 4'd1 << clr_ch;
         else                               clr_ctx = '0;
         tick();
         if (done) begin
            got = 1;
            lat = i;
         end
      end
      clr_ctx = '0;
      check({tag, " latency"}, 32'(lat), 32'd8);
      check({tag, " done_ch"}, 32'(done_ch), 32'(ch));
      check({tag, " cnt"}, 32'(match_cnt), 32'(ecnt));
      check({tag, " map"}, 32'(match_map), 32'(emap));
      tick();
      check({tag, " done pulse"}, 32'(done), 32'd0);
      check({tag, " idle"}, 32'(busy), 32'd0);
      check({tag, " hold"}, {20'd0, match_cnt, match_map}, {20'd0, ecnt, emap});
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
   endtask

   initial begin
      int order [5];
      int gcyc;
      int pcyc;
      int ng;
      int seen_done;
      bit got;

      rst = 1'b1; req = '0; word_in = '0; clr_ctx = '0;

      tbl[0]  = '{0, 8'h36, 0,  0, 4'd2, 8'h12};  // single word, leaves ch0 at Z
      tbl[1]  = '{0, 8'hC0, 0,  0, 4'd1, 8'h40};  // carry from Z
      tbl[2]  = '{1, 8'hC0, 0,  0, 4'd0, 8'h00};  // fresh channel
      tbl[3]  = '{1, 8'h36, 0,  0, 4'd2, 8'h12};
      tbl[4]  = '{1, 8'hDB, 0,  0, 4'd3, 8'h49};  // overlap, max matches
      tbl[5]  = '{2, 8'hDB, 0,  0, 4'd2, 8'h09};
      tbl[6]  = '{3, 8'h55, 0,  0, 4'd0, 8'h00};  // leaves ch3 at ZO
      tbl[7]  = '{3, 8'hFF, 0,  0, 4'd1, 8'h80};  // match on bit 7 from ZO
      tbl[8]  = '{2, 8'h33, 0,  0, 4'd2, 8'h11};
      tbl[9]  = '{2, 8'h00, 0,  4, 4'd0, 8'h00};  // clears ch0 while ch2 shifts
      tbl[10] = '{0, 8'hC0, 0,  0, 4'd0, 8'h00};
      tbl[11] = '{0, 8'h36, 0,  3, 4'd2, 8'h12};  // clear during own shift
      tbl[12] = '{0, 8'hC0, 0,  0, 4'd0, 8'h00};
      tbl[13] = '{0, 8'h36, 0,  0, 4'd2, 8'h12};
      tbl[14] = '{0, 8'hC0, 0, -1, 4'd0, 8'h00};  // clear on grant edge
      tbl[15] = '{3, 8'h36, 0,  0, 4'd2, 8'h12};

      repeat (3) tick();
      check("reset gnt", 32'(gnt), 32'd0);
      check("reset busy/done", {30'd0, busy, done}, 32'd0);
      check("reset results", {18'd0, done_ch, match_cnt, match_map}, 32'd0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 16; i++) begin
         run_job(tbl[i].ch, tbl[i].w, tbl[i].clr_ch, tbl[i].clr_step,
                 tbl[i].cnt, tbl[i].map, $sformatf("vec%0d", i));
      end

      // Round robin with all requests held high from a fresh reset.
      do_reset();
      order   = '{0, 1, 2, 3, 0};
      word_in = {4{8'hFF}};
      req     = 4'hF;
      ng      = 0;
      pcyc    = 0;
      for (int i = 0; i < 80 && ng < 5; i++) begin
         tick();
         if (gnt != 4'b0) begin
            gcyc = cyc;
            check($sformatf("rr gnt%0d", ng), 32'(gnt), 32'd1 << order[ng]);
            if (ng > 0) check($sformatf("rr gap%0d", ng), 32'(gcyc - pcyc), 32'd10);
            pcyc = gcyc;
            ng++;
         end
      end
      req = '0;
      check("rr grant count", 32'(ng), 32'd5);
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         tick();
         if (!busy) got = 1;
      end
      check("rr drain", 32'(busy), 32'd0);

      // Reset in the middle of a job: no done, everything cleared.
      run_job(3, 8'h36, 0, 0, 4'd2, 8'h12, "pre-rst");
      word_in[31:24] = 8'h36;
      req[3] = 1'b1;
      got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         tick();
         if (gnt != 4'b0) got = 1;
      end
      req = '0;
      check("midrst gnt", 32'(gnt), 32'h8);
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst outputs", {14'd0, gnt, busy, done, done_ch, match_cnt, match_map}, 32'd0);
      seen_done = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done || busy) seen_done++;
      end
      check("midrst no done", 32'(seen_done), 32'd0);
      run_job(3, 8'hC0, 0, 0, 4'd0, 8'h00, "post-rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
